btn_conditioner: RTL

// Downstream consumer of the 100 Hz divided clock in input_control. Samples N raw push-buttons on each

---
 rtl/input_ctrl_pkg.sv | 19 +
 rtl/btn_fsm.sv | 178 +++++++++++++++++
 rtl/btn_conditioner.sv | 77 +++++++
 3 files changed

// File: rtl/input_ctrl_pkg.sv
// Shared definitions for the input-control block: per-button state encoding
// and default debounce timing, in units of 100 Hz samples.
package input_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PCHK = 3'd1,
      HELD = 3'd2,
      LONG = 3'd3,
      RCHK = 3'd4
   } btn_state_t;

   localparam int DEF_N_BTN      = 4;
   localparam int DEF_STABLE_SMP = 3;
   localparam int DEF_LONG_SMP   = 100;
   localparam int DEF_REPEAT_SMP = 20;
   localparam int DEF_ACTIVE_LOW = 1;

endpackage

// File: rtl/btn_fsm.sv
// One debounced button: press/release qualification, long-press and auto-repeat.
// The state advances only on cycles where tick is high. All pulses are registered.
module btn_fsm
   import input_ctrl_pkg::*;
#(
   parameter int STABLE_SMP = DEF_STABLE_SMP,
   parameter int LONG_SMP   = DEF_LONG_SMP,
   parameter int REPEAT_SMP = DEF_REPEAT_SMP
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic pressed,
   output logic level,
   output logic press,
   output logic rel,
   output logic long_pls,
   output logic rpt_pls
);

   localparam int CNT_W  = $clog2(STABLE_SMP + 1);
   localparam int HOLD_W = $clog2(LONG_SMP + 1);
   localparam int RPT_W  = $clog2(REPEAT_SMP + 1);

   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_SMP);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_SMP);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
   localparam logic [RPT_W-1:0]  RPT_MAX  = RPT_W'(REPEAT_SMP);
   localparam logic [RPT_W-1:0]  RPT_ONE  = RPT_W'(1);

   btn_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
   logic [RPT_W-1:0]  rpt_q, rpt_d, rpt_inc;
   logic              ret_long_q, ret_long_d;
   logic              level_q, level_d;
   logic              press_q, press_d;
   logic              rel_q, rel_d;
   logic              long_q, long_d;
   logic              rpt_pls_q, rpt_pls_d;

   // Saturating increments: counters park at their terminal value instead of wrapping.
   assign cnt_inc  = (cnt_q == CNT_MAX)   ? CNT_MAX  : cnt_q + CNT_ONE;
   assign hold_inc = (hold_q == HOLD_MAX) ? HOLD_MAX : hold_q + HOLD_ONE;
   assign rpt_inc  = (rpt_q == RPT_MAX)   ? RPT_MAX  : rpt_q + RPT_ONE;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      rpt_d      = rpt_q;
      ret_long_d = ret_long_q;
      level_d    = level_q;
      press_d    = 1'b0;
      rel_d      = 1'b0;
      long_d     = 1'b0;
      rpt_pls_d  = 1'b0;

      if (tick) begin
         unique case (state_q)
            IDLE: begin
               if (pressed) begin
                  if (CNT_ONE == CNT_MAX) begin
                     state_d = HELD;
                     press_d = 1'b1;
                     level_d = 1'b1;
                     hold_d  = '0;
                     cnt_d   = '0;
                  end else begin
                     state_d = PCHK;
                     cnt_d   = CNT_ONE;
                  end
               end
            end

            PCHK: begin
               if (pressed) begin
                  if (cnt_inc == CNT_MAX) begin
                     state_d = HELD;
                     press_d = 1'b1;
                     level_d = 1'b1;
                     hold_d  = '0;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end

            HELD, LONG: begin
               if (pressed) begin
                  if (state_q == HELD) begin
                     hold_d = hold_inc;
                     if (hold_inc == HOLD_MAX) begin
                        state_d = LONG;
                        long_d  = 1'b1;
                        rpt_d   = '0;
                     end
                  end else if (rpt_inc == RPT_MAX) begin
                     rpt_pls_d = 1'b1;
                     rpt_d     = '0;
                  end else begin
                     rpt_d = rpt_inc;
                  end
               end else if (CNT_ONE == CNT_MAX) begin
                  state_d = IDLE;
                  rel_d   = 1'b1;
                  level_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  // Remember where we came from so a release glitch resumes in place.
                  state_d    = RCHK;
                  cnt_d      = CNT_ONE;
                  ret_long_d = (state_q == LONG);
               end
            end

            RCHK: begin
               if (!pressed) begin
                  if (cnt_inc == CNT_MAX) begin
                     state_d = IDLE;
                     rel_d   = 1'b1;
                     level_d = 1'b0;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = ret_long_q ? LONG : HELD;
                  cnt_d   = '0;
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hold_q     <= '0;
         rpt_q      <= '0;
         ret_long_q <= 1'b0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         rel_q      <= 1'b0;
         long_q     <= 1'b0;
         rpt_pls_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         rpt_q      <= rpt_d;
         ret_long_q <= ret_long_d;
         level_q    <= level_d;
         press_q    <= press_d;
         rel_q      <= rel_d;
         long_q     <= long_d;
         rpt_pls_q  <= rpt_pls_d;
      end
   end

   assign level    = level_q;
   assign press    = press_q;
   assign rel      = rel_q;
   assign long_pls = long_q;
   assign rpt_pls  = rpt_pls_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizes clk100 and the raw pins into clk,
// turns clk100 rising edges into a sample strobe and debounces each button.
module btn_conditioner
   import input_ctrl_pkg::*;
#(
   parameter int N_BTN      = DEF_N_BTN,
   parameter int STABLE_SMP = DEF_STABLE_SMP,
   parameter int LONG_SMP   = DEF_LONG_SMP,
   parameter int REPEAT_SMP = DEF_REPEAT_SMP,
   parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk100,
   input  logic [N_BTN-1:0] btn_raw,
   output logic             sample_tick,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long,
   output logic [N_BTN-1:0] btn_repeat
);

   logic [1:0]       clk_sync_q, clk_sync_d;
   logic             clk_prev_q, clk_prev_d;
   logic             tick_q, tick_d;
   logic [N_BTN-1:0] btn_s1_q, btn_s1_d;
   logic [N_BTN-1:0] btn_s2_q, btn_s2_d;
   logic [N_BTN-1:0] pressed;

   // Edge detect is registered so the strobe lands 3 clk after the clk100 edge.
   always_comb begin
      clk_sync_d = {clk_sync_q[0], clk100};
      clk_prev_d = clk_sync_q[1];
      tick_d     = clk_sync_q[1] & ~clk_prev_q;
      btn_s1_d   = btn_raw;
      btn_s2_d   = btn_s1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q <= '0;
         clk_prev_q <= 1'b0;
         tick_q     <= 1'b0;
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
      end else begin
         clk_sync_q <= clk_sync_d;
         clk_prev_q <= clk_prev_d;
         tick_q     <= tick_d;
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
      end
   end

   assign pressed     = (ACTIVE_LOW != 0) ? ~btn_s2_q : btn_s2_q;
   assign sample_tick = tick_q;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_fsm #(
         .STABLE_SMP (STABLE_SMP),
         .LONG_SMP   (LONG_SMP),
         .REPEAT_SMP (REPEAT_SMP)
      ) u_fsm (
         .clk      (clk),
         .rst_n    (rst_n),
         .tick     (tick_q),
         .pressed  (pressed[i]),
         .level    (btn_level[i]),
         .press    (btn_press[i]),
         .rel      (btn_release[i]),
         .long_pls (btn_long[i]),
         .rpt_pls  (btn_repeat[i])
      );
   end

endmodule
